// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin lock arbiter: default sizing and
// conversions between one-hot vectors and requester indices.
package arb_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 8;
   localparam int MAX_REQ      = 16;

   function automatic logic [3:0] onehotToIdx(input logic [MAX_REQ-1:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   function automatic logic [MAX_REQ-1:0] idxToOnehot(input logic [3:0] idx);
      logic [MAX_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority encoder: returns the first set request bit at or after ptr,
// wrapping from N-1 back to 0.
module rr_picker
   import arb_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           found,
   output logic [IDW-1:0] winner
);

   localparam logic [IDW:0] NVAL = (IDW+1)'(N);

   logic [N-1:0]   w_rot;
   logic [N-1:0]   w_lowest;
   logic [IDW-1:0] w_off;
   logic [IDW:0]   w_sum;
   logic [IDW:0]   w_wrapped;

   // Rotate so that the requester at ptr lands on bit 0
   always_comb begin
      w_rot = '0;
      for (int i = 0; i < N; i++) begin
         int j;
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         w_rot[i] = req[IDW'(j)];
      end
   end

   assign w_lowest  = w_rot & (-w_rot);
   assign w_off     = IDW'(onehotToIdx(MAX_REQ'(w_lowest)));
   assign w_sum     = {1'b0, ptr} + {1'b0, w_off};
   assign w_wrapped = w_sum - NVAL;
   assign found     = |w_rot;
   assign winner    = (w_sum >= NVAL) ? w_wrapped[IDW-1:0] : w_sum[IDW-1:0];

endmodule

// File: rtl/lock_rr_arbiter.sv
// Round-robin arbiter whose holder may keep the grant by asserting lock, up to
// MAX_HOLD consecutive cycles before it is forced to release.
module lock_rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         lock,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 timeout
);

   localparam int IDW = $clog2(N);
   localparam int HW  = $clog2(MAX_HOLD);
   localparam logic [HW-1:0]  CAP  = HW'(MAX_HOLD - 1);
   localparam logic [IDW-1:0] LAST = IDW'(N - 1);

   logic [N-1:0]   r_grant;
   logic           r_valid;
   logic [IDW-1:0] r_grantId;
   logic           r_timeout;
   logic [IDW-1:0] r_ptr;
   logic [HW-1:0]  r_holdCnt;

   logic [N-1:0]   w_nextGrant;
   logic           w_nextValid;
   logic [IDW-1:0] w_nextGrantId;
   logic           w_nextTimeout;
   logic [IDW-1:0] w_nextPtr;
   logic [HW-1:0]  w_nextHoldCnt;

   logic           w_found;
   logic [IDW-1:0] w_winner;
   logic           w_holdReq;

   rr_picker #(.N(N), .IDW(IDW)) u_picker (
      .req    (req),
      .ptr    (r_ptr),
      .found  (w_found),
      .winner (w_winner)
   );

   assign w_holdReq = r_valid & req[r_grantId] & lock[r_grantId];

   // Keep while the holder locks and is under its cap; otherwise re-arbitrate.
   // Reaching the release branch with w_holdReq set means the cap forced it.
   always_comb begin
      w_nextGrant   = r_grant;
      w_nextValid   = r_valid;
      w_nextGrantId = r_grantId;
      w_nextTimeout = 1'b0;
      w_nextPtr     = r_ptr;
      w_nextHoldCnt = r_holdCnt;
      if (w_holdReq && (r_holdCnt != CAP)) begin
         w_nextHoldCnt = r_holdCnt + 1'b1;
      end else if (w_found) begin
         w_nextGrant   = N'(idxToOnehot(4'(w_winner)));
         w_nextValid   = 1'b1;
         w_nextGrantId = w_winner;
         w_nextTimeout = w_holdReq;
         w_nextPtr     = (w_winner == LAST) ? '0 : w_winner + 1'b1;
         w_nextHoldCnt = '0;
      end else begin
         w_nextGrant   = '0;
         w_nextValid   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant   <= '0;
         r_valid   <= 1'b0;
         r_grantId <= '0;
         r_timeout <= 1'b0;
         r_ptr     <= '0;
         r_holdCnt <= '0;
      end else begin
         r_grant   <= w_nextGrant;
         r_valid   <= w_nextValid;
         r_grantId <= w_nextGrantId;
         r_timeout <= w_nextTimeout;
         r_ptr     <= w_nextPtr;
         r_holdCnt <= w_nextHoldCnt;
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_valid;
   assign grant_id    = r_grantId;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_lock_rr_arbiter.sv
// Directed and random checks of lock_rr_arbiter against a cycle-level
// reference model of the arbitration rules.
module tb_lock_rr_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] lock;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [1:0]   grant_id;
   logic         timeout;

   int checks = 0;
   int errors = 0;

   int mId    = 0;
   int mPtr   = 0;
   int mCnt   = 0;
   bit mValid = 0;
   bit mTimeout = 0;

   lock_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .lock        (lock),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .timeout     (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: advance one edge using the sampled inputs
   task automatic modelStep(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk);
      bit held;
      int w;
      if (r) begin
         mId = 0; mPtr = 0; mCnt = 0; mValid = 0; mTimeout = 0;
         return;
      end
      held = mValid && rq[mId] && lk[mId];
      mTimeout = 0;
      if (held && mCnt < MAX_HOLD - 1) begin
         mCnt = mCnt + 1;
      end else begin
         w = -1;
         for (int i = 0; i < N; i++) begin
            if (w < 0 && rq[(mPtr + i) % N]) w = (mPtr + i) % N;
         end
         if (w >= 0) begin
            mTimeout = held;
            mId = w; mValid = 1; mCnt = 0; mPtr = (w + 1) % N;
         end else begin
            mValid = 0;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [N-1:0] expGrant;
      expGrant = mValid ? N'(1 << mId) : '0;
      checkVal({tag, ".grant"}, 32'(grant), 32'(expGrant));
      checkVal({tag, ".valid"}, 32'(grant_valid), 32'(mValid));
      checkVal({tag, ".id"}, 32'(grant_id), 32'(mId));
      checkVal({tag, ".timeout"}, 32'(timeout), 32'(mTimeout));
   endtask

   task automatic applyStimulus(input string tag, input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk);
      @(negedge clk);
      rst  = r;
      req  = rq;
      lock = lk;
      modelStep(r, rq, lk);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      int toCount;
      rst  = 1'b1;
      req  = '0;
      lock = '0;

      $display("[TB] reset with requests pending");
      applyStimulus("reset0", 1'b1, 4'b1111, 4'b0000);
      applyStimulus("reset1", 1'b1, 4'b1111, 4'b0000);
      checkVal("reset_grant", 32'(grant), 32'h0);
      checkVal("reset_timeout", 32'(timeout), 32'h0);

      $display("[TB] rotation without lock");
      begin
         logic [N-1:0] expRot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
         for (int i = 0; i < 5; i++) begin
            applyStimulus("rotate", 1'b0, 4'b1111, 4'b0000);
            checkVal("rotate_seq", 32'(grant), 32'(expRot[i]));
         end
      end

      $display("[TB] lock cap");
      applyStimulus("capreset", 1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < MAX_HOLD; i++) begin
         applyStimulus("caphold", 1'b0, 4'b0011, 4'b0001);
         checkVal("cap_hold_grant", 32'(grant), 32'h1);
      end
      applyStimulus("capforce", 1'b0, 4'b0011, 4'b0001);
      checkVal("cap_force_grant", 32'(grant), 32'h2);
      checkVal("cap_force_timeout", 32'(timeout), 32'h1);
      applyStimulus("capback", 1'b0, 4'b0011, 4'b0001);
      checkVal("cap_back_grant", 32'(grant), 32'h1);
      checkVal("cap_back_timeout", 32'(timeout), 32'h0);

      $display("[TB] early release");
      applyStimulus("early", 1'b0, 4'b0101, 4'b0001);
      applyStimulus("early", 1'b0, 4'b0101, 4'b0001);
      applyStimulus("earlydrop", 1'b0, 4'b0100, 4'b0001);
      checkVal("early_grant", 32'(grant), 32'h4);
      checkVal("early_valid", 32'(grant_valid), 32'h1);
      checkVal("early_timeout", 32'(timeout), 32'h0);

      $display("[TB] sole locked requester");
      toCount = 0;
      for (int i = 0; i < 3 * MAX_HOLD; i++) begin
         applyStimulus("sole", 1'b0, 4'b1000, 4'b1000);
         checkVal("sole_id", 32'(grant_id), 32'h3);
         if (timeout) toCount++;
      end
      checkVal("sole_timeouts", 32'(toCount), 32'd2);

      $display("[TB] reset during a locked grant");
      applyStimulus("midlock", 1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) applyStimulus("midlock", 1'b0, 4'b0100, 4'b0100);
      applyStimulus("midlockrst", 1'b1, 4'b0100, 4'b0100);
      checkVal("midlock_grant", 32'(grant), 32'h0);
      applyStimulus("midlockafter", 1'b0, 4'b0110, 4'b0000);
      checkVal("midlock_after", 32'(grant), 32'h2);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus("random", ($urandom_range(0, 49) == 0), N'($urandom), N'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lock_rr_arbiter.md
# lock_rr_arbiter

Round-robin arbiter with requester-controlled grant locking and a bounded hold time. It shares one downstream resource among N requesters and is the next-generation replacement for the fixed priority-lock arbiter. A requester may keep the grant across multiple cycles by holding `lock`. A hold counter forces release after MAX_HOLD cycles, so no requester can starve the others.

## Interface
- N, 4, number of requesters (2..16)
- MAX_HOLD, 8, max consecutive grant cycles per grant instance (>=2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector, one bit per requester
- lock  input  N  per-requester hold request; ignored unless matching req bit is set
- grant  output  N  registered one-hot grant, or all zero
- grant_valid  output  1  registered; high iff grant != 0
- grant_id  output  $clog2(N)  registered index of the granted requester; holds its last value when grant_valid=0
- timeout  output  1  registered one-cycle pulse on a forced release

## Operation
- State: holder h (grant_id, valid flag), rotation pointer ptr, hold counter hold_cnt (width $clog2(MAX_HOLD)).
- Next state is evaluated at every rising edge from sampled req, lock and the current state.
- Keep: valid h AND req[h] AND lock[h] AND hold_cnt < MAX_HOLD-1 -> grant unchanged, hold_cnt+1.
- Release: any other case with valid h, or no holder. The arbiter picks the first set req bit in rotation order starting at ptr.
  - When h is valid, ptr equals h+1 mod N, so h is considered last.
- Winner w: grant = onehot(w), grant_id = w, hold_cnt = 0, ptr = w+1 mod N (wraps N-1 -> 0).
- No set req bit: grant = 0, grant_valid = 0; ptr and grant_id are unchanged.
- Forced release: the release is caused only by hold_cnt = MAX_HOLD-1 while req[h] and lock[h] are high. timeout = 1 for the cycle of the new grant, otherwise 0.
- Re-grant to the same requester:
  - Sole requester with lock=0: re-granted every cycle, hold_cnt stays 0.
  - Sole requester that timed out: re-granted immediately, hold_cnt resets to 0, and timeout still pulses.
- lock bits with req low have no effect. req and lock changes take effect only at edges.
- Reset: grant = 0, grant_valid = 0, grant_id = 0, timeout = 0, ptr = 0, hold_cnt = 0, no holder. Reset overrides a grant in progress at the same edge.

## Timing
- Request to grant latency is 1 cycle: req sampled at edge k -> grant visible after edge k.
- Handover has no bubble: the holder's release and the next requester's grant happen at the same edge.
- A locked grant lasts at most MAX_HOLD consecutive cycles.
- timeout is coincident with the first cycle of the following grant.
- After reset release, requester 0 has highest priority.
- All outputs are flop outputs. There is no combinational path from inputs to outputs.

## Structure
- Shared package arb_pkg holds:
  - default values for N and MAX_HOLD;
  - the onehot-to-index function;
  - the index-to-onehot function.
- Sub-module rr_picker: combinational rotate-priority encoder. Inputs are req[N-1:0] and ptr; outputs are found and winner index.
- lock_rr_arbiter holds the registers, the keep/release decision and the timeout logic.

## Test plan
- Reset: hold rst high for 2 edges with req=1111 -> grant=0000, grant_valid=0, grant_id=0, timeout=0. The first edge after release gives grant=0001.
- Rotation without lock: req=1111, lock=0000 -> grant cycles 0001, 0010, 0100, 1000, 0001, with timeout always 0.
- Lock cap, MAX_HOLD=8: req=0011, lock=0001 -> grant=0001 for exactly 8 cycles, then 0010 with timeout=1 for one cycle. After that, 0001 is granted again.
- Early release: req=0101, lock=0001. Drop req[0] in the 3rd locked cycle -> grant=0100 at that same edge, timeout=0, grant_valid never drops.
- Sole requester: req=1000, lock=1000, MAX_HOLD=8 -> grant=1000 continuously, with a timeout pulse every 8 cycles and grant_id=3 throughout.
- Reset mid-lock: assert rst during the 4th cycle of a locked grant -> all outputs at reset values on the next edge. After rst drops, req=0110 gives grant=0010 (ptr restarted at 0).
